// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares exmem port 2 between a priority display requester (0)
// and a starvation-protected game-logic requester (1), one access per cycle.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic                  i_lock0,
    input  logic                  i_lock1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait1;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic       w_gnt0;
    logic       w_gnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wait1   <= 4'd0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rvalid0 <= w_gnt0 & ~i_we0;
            r_rvalid1 <= w_gnt1 & ~i_we1;
            r_wait1   <= w_gnt1 ? 4'd0 : (i_req1 && r_wait1 < LP_MAX) ? r_wait1 + 4'd1 : r_wait1;
        end
    end

    // Starvation override beats any lock held by requester 0
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (r_wait1 == LP_MAX && i_req1)
                w_gnt1 = 1'b1;
            else if (r_state == OWN0 && i_lock0 && i_req0)
                w_gnt0 = 1'b1;
            else if (r_state == OWN1 && i_lock1 && i_req1)
                w_gnt1 = 1'b1;
            else if (i_req0)
                w_gnt0 = 1'b1;
            else if (i_req1)
                w_gnt1 = 1'b1;
        end
        w_next = w_gnt0 ? OWN0 : w_gnt1 ? OWN1 : IDLE;
    end

    assign o_gnt0      = w_gnt0;
    assign o_gnt1      = w_gnt1;
    assign o_rvalid0   = r_rvalid0;
    assign o_rvalid1   = r_rvalid1;
    assign o_rdata     = i_mem_rdata;
    assign o_mem_addr  = w_gnt0 ? i_addr0 : w_gnt1 ? i_addr1 : '0;
    assign o_mem_wdata = w_gnt0 ? i_wdata0 : w_gnt1 ? i_wdata1 : '0;
    assign o_mem_we    = (w_gnt0 & i_we0) | (w_gnt1 & i_we1);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, read latency, locks and starvation
// against a write-through one-cycle memory model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] mem [0:65535];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_lock0(lock0), .i_lock1(lock1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_we(mem_we), .i_mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'h5555;
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0; addr0 = 16'h0010; addr1 = 16'h0020;
        wdata0 = 16'hAAAA; wdata1 = 16'h0;
        step(); #1;
        chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0); chk("rst_we", mem_we, 0);
        step(); #1;
        chk("rst_rv0", rvalid0, 0); chk("rst_rv1", rvalid1, 0); chk("rst_gnt0b", gnt0, 0);
        step(); reset = 1'b0; we0 = 1'b0; #1;
        chk("rel_gnt0", gnt0, 1); chk("rel_gnt1", gnt1, 0);
        chk("rd0_addr", mem_addr, 16'h0010); chk("rd0_we", mem_we, 0);
        step(); req0 = 1'b0; #1;
        chk("rd0_rv", rvalid0, 1); chk("rd0_data", rdata, 16'hBEEF); chk("rd0_rv1", rvalid1, 0);
        chk("rd1_gnt", gnt1, 1); chk("rd1_addr", mem_addr, 16'h0020);
        step(); req1 = 1'b0; #1;
        chk("rd1_rv", rvalid1, 1); chk("rd1_data", rdata, 16'h5555); chk("idle_rv0", rvalid0, 0);
        chk("idle_gnt", {gnt0, gnt1}, 0); chk("idle_addr", mem_addr, 0);
        step(); req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = 16'h1234; #1;
        chk("wr_gnt1", gnt1, 1); chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 16'h0200); chk("wr_data", mem_wdata, 16'h1234);
        step(); we1 = 1'b0; #1;
        chk("rb_gnt1", gnt1, 1); chk("rb_we", mem_we, 0); chk("wr_norv", rvalid1, 0);
        step(); req1 = 1'b0; #1;
        chk("rb_rv", rvalid1, 1); chk("rb_data", rdata, 16'h1234); chk("rb_we0", mem_we, 0);
        for (int i = 0; i < 10; i++) begin
            step(); req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0030; addr1 = 16'h0040; #1;
            chk($sformatf("starve_gnt0_%0d", i), gnt0, (i % 5 != 4));
            chk($sformatf("starve_gnt1_%0d", i), gnt1, (i % 5 == 4));
            chk($sformatf("starve_rv0_%0d", i), rvalid0, (i > 0 && (i - 1) % 5 != 4));
            chk($sformatf("starve_rv1_%0d", i), rvalid1, (i == 5));
        end
        step(); req0 = 1'b0; lock1 = 1'b1; #1;
        chk("lock_l0", gnt1, 1);
        step(); req0 = 1'b1; #1;
        chk("lock_l1_g1", gnt1, 1); chk("lock_l1_g0", gnt0, 0);
        step(); #1;
        chk("lock_l2_g1", gnt1, 1); chk("lock_l2_g0", gnt0, 0);
        step(); req1 = 1'b0; lock1 = 1'b0; #1;
        chk("lock_rel_g0", gnt0, 1); chk("lock_rel_g1", gnt1, 0);
        for (int i = 0; i < 6; i++) begin
            step(); req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; #1;
            chk($sformatf("lock0_gnt0_%0d", i), gnt0, (i != 4));
            chk($sformatf("lock0_gnt1_%0d", i), gnt1, (i == 4));
        end
        step(); lock0 = 1'b0; #1;
        chk("mid_gnt0", gnt0, 1); chk("mid_wait", dut.r_wait1, 1);
        step(); reset = 1'b1; req0 = 1'b0; req1 = 1'b0; #1;
        chk("mid_rst_gnt0", gnt0, 0); chk("mid_rst_gnt1", gnt1, 0);
        step(); reset = 1'b0; #1;
        chk("mid_rv0", rvalid0, 0); chk("mid_wait0", dut.r_wait1, 0);
        chk("mid_state", dut.r_state, 0); chk("mid_idle", {gnt0, gnt1}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
